// File: rtl/risc16_bus_pkg.sv
// Shared types and constants for the risc16ba data-memory bus and its read-side dump engine.
package risc16_bus_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [15:0] word_t;

  localparam addr_t IMAGE_BASE = 16'hC000;
  localparam addr_t IMAGE_LAST = 16'hFFFF;
  localparam addr_t LED_ADDR0  = 16'h0200;
  localparam addr_t LED_ADDR2  = 16'h0202;

  typedef enum logic [2:0] {IDLE, READ, SEND_HI, SEND_LO, FIN} dump_state_t;

  localparam int unsigned CNT_W = 17;
  localparam logic [CNT_W-1:0] CNT_ONE = 17'd1;

  // True when byte index cnt is the last byte of a line; line_bytes is a power of two.
  function automatic logic line_end(input logic [CNT_W-1:0] cnt, input int unsigned line_bytes);
    logic [CNT_W-1:0] mask;
    mask = CNT_W'(line_bytes - 32'd1);
    return (cnt & mask) == mask;
  endfunction

endpackage

// File: rtl/risc16ba_dump_reader.sv
// Sweeps a word-aligned window of data memory through the bus read strobe and streams it out
// as big-endian bytes with per-line and end-of-dump markers.
module risc16ba_dump_reader
  import risc16_bus_pkg::*;
#(
  parameter addr_t       BASE_ADDR  = IMAGE_BASE,
  parameter addr_t       LAST_ADDR  = IMAGE_LAST,
  parameter int unsigned LINE_BYTES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output addr_t      daddr,
  output logic       doe,
  input  word_t      ddin,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_eol,
  output logic       out_last
);

  localparam addr_t FINAL_WORD = LAST_ADDR & 16'hFFFE;

  dump_state_t      state_q;
  addr_t            addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       lo_byte_q;
  logic             final_word;

  // Termination is by address compare so the wrap past 0xFFFE is never issued on the bus.
  assign final_word = (addr_q == FINAL_WORD);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= BASE_ADDR;
      cnt_q     <= '0;
      lo_byte_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      doe       <= 1'b0;
      daddr     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_eol   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            addr_q  <= BASE_ADDR;
            cnt_q   <= '0;
            busy    <= 1'b1;
            doe     <= 1'b1;
            daddr   <= BASE_ADDR;
            state_q <= READ;
          end
        end
        READ: begin
          // Read data is only valid while doe is high, so capture both bytes now.
          lo_byte_q <= ddin[7:0];
          doe       <= 1'b0;
          daddr     <= '0;
          out_valid <= 1'b1;
          out_data  <= ddin[15:8];
          out_eol   <= line_end(cnt_q, LINE_BYTES);
          out_last  <= 1'b0;
          state_q   <= SEND_HI;
        end
        SEND_HI: begin
          if (out_ready) begin
            cnt_q    <= cnt_q + CNT_ONE;
            out_data <= lo_byte_q;
            out_eol  <= line_end(cnt_q + CNT_ONE, LINE_BYTES);
            out_last <= final_word;
            state_q  <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (out_ready) begin
            cnt_q     <= cnt_q + CNT_ONE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_eol   <= 1'b0;
            out_last  <= 1'b0;
            if (final_word) begin
              done    <= 1'b1;
              state_q <= FIN;
            end else begin
              addr_q  <= addr_q + 16'd2;
              doe     <= 1'b1;
              daddr   <= addr_q + 16'd2;
              state_q <= READ;
            end
          end
        end
        FIN: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_risc16ba_dump_reader.sv
// Scoreboard bench: a small-window instance and a default-window instance share one clock/reset.
module tb_risc16ba_dump_reader;
  import risc16_bus_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       eol;
    logic       last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start [2];
  logic        busy  [2];
  logic        done  [2];
  logic        doe   [2];
  logic        valid [2];
  logic        ready [2];
  logic        eol   [2];
  logic        last  [2];
  logic [15:0] daddr [2];
  logic [15:0] ddin  [2];
  logic [7:0]  data  [2];
  logic        s_ready;
  logic        rand_ready;

  int   vectors = 0;
  int   miscompares = 0;
  int   dones [2];
  int   exp_dones [2];
  exp_t exp_q [2][$];
  logic [15:0] addr_q [2][$];
  logic stall [2];
  exp_t held [2];

  always #5 clk = ~clk;

  // Memory contents: small window 0x11..0x88, default window addr[7:0]^addr[15:8].
  function automatic logic [7:0] mem_byte(input int k, input int a);
    logic [15:0] w;
    w = a[15:0];
    if (k == 0) return 8'((a + 1) * 17);
    return w[7:0] ^ w[15:8];
  endfunction

  assign ddin[0]  = {mem_byte(0, int'(daddr[0])), mem_byte(0, int'(daddr[0]) + 1)};
  assign ddin[1]  = {mem_byte(1, int'(daddr[1])), mem_byte(1, int'(daddr[1]) + 1)};
  assign ready[0] = s_ready;
  assign ready[1] = 1'b1;

  risc16ba_dump_reader #(
    .BASE_ADDR (16'h0000),
    .LAST_ADDR (16'h0007),
    .LINE_BYTES(8)
  ) u_small (
    .clk      (clk),
    .rst      (rst_n),
    .start    (start[0]),
    .busy     (busy[0]),
    .done     (done[0]),
    .daddr    (daddr[0]),
    .doe      (doe[0]),
    .ddin     (ddin[0]),
    .out_data (data[0]),
    .out_valid(valid[0]),
    .out_ready(ready[0]),
    .out_eol  (eol[0]),
    .out_last (last[0])
  );

  risc16ba_dump_reader #(
    .BASE_ADDR (16'hC000),
    .LAST_ADDR (16'hFFFF),
    .LINE_BYTES(8)
  ) u_big (
    .clk      (clk),
    .rst      (rst_n),
    .start    (start[1]),
    .busy     (busy[1]),
    .done     (done[1]),
    .daddr    (daddr[1]),
    .doe      (doe[1]),
    .ddin     (ddin[1]),
    .out_data (data[1]),
    .out_valid(valid[1]),
    .out_ready(ready[1]),
    .out_eol  (eol[1]),
    .out_last (last[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference stream: every byte of the window in address order, big-endian within a word.
  task automatic push_dump(input int k, input bit count_done);
    int base;
    int lst;
    exp_t e;
    base = (k == 0) ? 0 : 32'hC000;
    lst  = (k == 0) ? 7 : 32'hFFFF;
    for (int a = base; a <= lst; a++) begin
      e.data = mem_byte(k, a);
      e.eol  = ((a - base + 1) % 8) == 0;
      e.last = (a == lst);
      exp_q[k].push_back(e);
    end
    for (int a = base; a <= lst; a += 2) addr_q[k].push_back(16'(a));
    if (count_done) exp_dones[k]++;
  endtask

  task automatic pulse(input int k);
    @(posedge clk);
    #1 start[k] = 1'b1;
    @(posedge clk);
    #1 start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget, output int cyc);
    cyc = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done[k]) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) fail_now($sformatf("timeout_done dut%0d", k));
  endtask

  always @(posedge clk) begin
    #1 s_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // Monitor: pops expected bytes/addresses as the DUTs present them.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      for (int k = 0; k < 2; k++) begin
        if (stall[k])
          chk($sformatf("hold dut%0d", k), 32'({valid[k], data[k], eol[k], last[k]}),
              32'({1'b1, held[k]}));
        if (valid[k] && ready[k]) begin
          if (exp_q[k].size() == 0) begin
            fail_now($sformatf("extra_byte dut%0d got %02h", k, data[k]));
          end else begin
            e = exp_q[k].pop_front();
            chk($sformatf("byte dut%0d", k), 32'({data[k], eol[k], last[k]}), 32'(e));
          end
        end
        if (doe[k]) begin
          if (addr_q[k].size() == 0) fail_now($sformatf("extra_doe dut%0d daddr %04h", k, daddr[k]));
          else chk($sformatf("daddr dut%0d", k), 32'(daddr[k]), 32'(addr_q[k].pop_front()));
        end
        if (done[k]) begin
          dones[k]++;
          chk($sformatf("bytes_left_at_done dut%0d", k), 32'(exp_q[k].size()), 32'd0);
          chk($sformatf("reads_left_at_done dut%0d", k), 32'(addr_q[k].size()), 32'd0);
        end
        stall[k] = valid[k] && !ready[k];
        held[k]  = {data[k], eol[k], last[k]};
      end
    end else begin
      stall[0] = 1'b0;
      stall[1] = 1'b0;
    end
  end

  initial begin
    int  cyc;
    bit  found;
    rst_n      = 1'b0;
    start[0]   = 1'b0;
    start[1]   = 1'b0;
    rand_ready = 1'b0;
    s_ready    = 1'b1;
    dones[0] = 0; dones[1] = 0; exp_dones[0] = 0; exp_dones[1] = 0;
    stall[0] = 1'b0; stall[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset / idle
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_ctrl dut%0d", k),
          32'({busy[k], done[k], doe[k], valid[k], eol[k], last[k]}), 32'd0);
      chk($sformatf("reset_daddr dut%0d", k), 32'(daddr[k]), 32'd0);
      chk($sformatf("reset_data dut%0d", k), 32'(data[k]), 32'd0);
    end
    repeat (10) begin
      @(negedge clk);
      chk("idle_doe", 32'({doe[1], doe[0]}), 32'd0);
    end

    // Small window, ready held high
    push_dump(0, 1'b1);
    pulse(0);
    chk("busy_after_start", 32'(busy[0]), 32'd1);
    wait_done(0, 60, cyc);
    chk("done_cycle", 32'(cyc), 32'd13);
    chk("busy_in_fin", 32'(busy[0]), 32'd1);
    @(negedge clk);
    chk("busy_after_fin", 32'({busy[0], done[0]}), 32'd0);

    // Backpressure at ~30% ready
    rand_ready = 1'b1;
    push_dump(0, 1'b1);
    pulse(0);
    wait_done(0, 800, cyc);
    rand_ready = 1'b0;
    repeat (2) @(negedge clk);

    // start while busy and in FIN is ignored; start in the next IDLE cycle is taken
    push_dump(0, 1'b1);
    pulse(0);
    repeat (5) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    wait_done(0, 60, cyc);
    start[0] = 1'b1;
    @(negedge clk);
    chk("idle_between_dumps", 32'(busy[0]), 32'd0);
    push_dump(0, 1'b1);
    @(posedge clk);
    #1 start[0] = 1'b0;
    wait_done(0, 60, cyc);
    chk("restart_done_cycle", 32'(cyc), 32'd13);
    repeat (3) @(negedge clk);

    // Reset during SEND_LO of the second word
    push_dump(0, 1'b0);
    pulse(0);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (valid[0] && data[0] == 8'h44) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_now("reset_point_not_reached");
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q[0].delete();
    addr_q[0].delete();
    chk("after_abort", 32'({busy[0], valid[0], done[0], doe[0]}), 32'd0);
    repeat (5) @(negedge clk);
    push_dump(0, 1'b1);
    pulse(0);
    wait_done(0, 60, cyc);
    chk("post_abort_done_cycle", 32'(cyc), 32'd13);

    // Default window
    push_dump(1, 1'b1);
    pulse(1);
    wait_done(1, 30000, cyc);
    chk("big_done_cycle", 32'(cyc), 32'd24577);
    @(negedge clk);
    chk("big_busy_after", 32'(busy[1]), 32'd0);
    repeat (3) @(negedge clk);

    chk("done_count_small", 32'(dones[0]), 32'(exp_dones[0]));
    chk("done_count_big", 32'(dones[1]), 32'(exp_dones[1]));
    chk("bytes_left_small", 32'(exp_q[0].size()), 32'd0);
    chk("bytes_left_big", 32'(exp_q[1].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
